// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide unit with HI/LO registers and D-stage stall generation.
// Define MDU_MADD_EN to make ops 6/7 (MADD/MADDU) multiply-accumulate long ops.

module mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        md_use_d,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OpMult  = 3'd0;
    localparam logic [2:0] OpMultu = 3'd1;
    localparam logic [2:0] OpDiv   = 3'd2;
    localparam logic [2:0] OpDivu  = 3'd3;
    localparam logic [2:0] OpMthi  = 3'd4;
    localparam logic [2:0] OpMtlo  = 3'd5;
    localparam logic [2:0] OpMadd  = 3'd6;
`ifdef MDU_MADD_EN
    localparam logic [2:0] OpMaddu = 3'd7;
`endif

    localparam logic [3:0] MultLoad = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DivLoad  = 4'(DIV_CYCLES - 1);

    typedef enum logic {StIdle, StRun} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic        pend_wr_q, pend_wr_d;

    logic        is_mul, is_div, is_madd, long_op, accept;
    logic        signed_mul, signed_div;
    logic [63:0] a_ext, b_ext, prod, acc_base, mul_res;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;

    always_comb begin
        is_madd = 1'b0;
`ifdef MDU_MADD_EN
        is_madd = (op == OpMadd) || (op == OpMaddu);
`endif
        is_mul  = (op == OpMult) || (op == OpMultu) || is_madd;
        is_div  = (op == OpDiv) || (op == OpDivu);
        long_op = is_mul || is_div;
    end

    // Multiply: sign/zero extend to 64 bits; low 64 bits of the product are exact either way.
    // A MADD accepted on the commit edge accumulates onto the value being committed.
    always_comb begin
        signed_mul = (op == OpMult) || (op == OpMadd);
        a_ext      = signed_mul ? {{32{a[31]}}, a} : {32'b0, a};
        b_ext      = signed_mul ? {{32{b[31]}}, b} : {32'b0, b};
        prod       = a_ext * b_ext;
        acc_base   = (state_q == StRun && pend_wr_q) ? {pend_hi_q, pend_lo_q} : {hi_q, lo_q};
        mul_res    = is_madd ? (acc_base + prod) : prod;
    end

    // Divide on magnitudes so the INT_MIN / -1 case wraps instead of overflowing.
    always_comb begin
        signed_div = (op == OpDiv);
        a_neg      = signed_div & a[31];
        b_neg      = signed_div & b[31];
        a_mag      = a_neg ? -a : a;
        b_mag      = b_neg ? -b : b;
        if (b_mag == 32'd0) begin
            b_mag = 32'd1;
        end
        q_mag = a_mag / b_mag;
        r_mag = a_mag % b_mag;
        quot  = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem   = a_neg ? -r_mag : r_mag;
    end

    assign accept = start && long_op && (state_q == StIdle || cnt_q == 4'd0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;

        unique case (state_q)
            StIdle: begin
                if (start && op == OpMthi) begin
                    hi_d = a;
                end else if (start && op == OpMtlo) begin
                    lo_d = a;
                end
            end
            StRun: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // A long op is taken in IDLE or on the final busy cycle (back-to-back issue).
        if (accept) begin
            pend_hi_d = is_div ? rem : mul_res[63:32];
            pend_lo_d = is_div ? quot : mul_res[31:0];
            pend_wr_d = is_mul || (b != 32'd0);
            cnt_d     = is_div ? DivLoad : MultLoad;
            state_d   = StRun;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    assign busy  = (state_q == StRun);
    assign stall = md_use_d && (busy || (start && long_op));
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed vectors plus randomized ops against a
// 64-bit arithmetic reference model of HI/LO and operation latency.

module tb_mdu_ctrl;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset, start, md_use_d, busy, stall;
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] m_hi, m_lo;

    mdu_ctrl #(
        .MULT_CYCLES (MC),
        .DIV_CYCLES  (DC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .md_use_d (md_use_d),
        .busy     (busy),
        .stall    (stall),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference model: sequential architectural semantics with plain 64-bit arithmetic.
    task automatic model_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                            output int lat);
        longint          sp;
        longint unsigned up;
        int              sx, sy;
        lat = 0;
        case (o)
            3'd0: begin
                sp = longint'($signed(x)) * longint'($signed(y));
                {m_hi, m_lo} = sp;
                lat = MC;
            end
            3'd1: begin
                up = {32'b0, x} * {32'b0, y};
                {m_hi, m_lo} = up;
                lat = MC;
            end
            3'd2: begin
                lat = DC;
                if (y != 0) begin
                    if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                        m_lo = x;
                        m_hi = 32'd0;
                    end else begin
                        sx = x;
                        sy = y;
                        m_lo = sx / sy;
                        m_hi = sx % sy;
                    end
                end
            end
            3'd3: begin
                lat = DC;
                if (y != 0) begin
                    m_lo = x / y;
                    m_hi = x % y;
                end
            end
            3'd4: m_hi = x;
            3'd5: m_lo = x;
            default: begin
`ifdef MDU_MADD_EN
                if (o == 3'd6) begin
                    sp = longint'($signed(x)) * longint'($signed(y));
                    up = {m_hi, m_lo} + longint'(sp);
                end else begin
                    up = {m_hi, m_lo} + {32'b0, x} * {32'b0, y};
                end
                {m_hi, m_lo} = up;
                lat = MC;
`endif
            end
        endcase
    endtask

    // Issue one op from idle; report busy length, stall in the start cycle and any
    // HI/LO change observed while busy.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int lat, output logic st, output logic chg);
        logic [31:0] h0, l0;
        int n;
        op = o; a = x; b = y; start = 1'b1;
        #1;
        st = stall;
        h0 = hi; l0 = lo;
        tick;
        start = 1'b0;
        chg = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            if (hi !== h0 || lo !== l0) chg = 1'b1;
            n++;
            tick;
        end
        lat = n;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b1; op = 3'd4; a = 32'hDEAD_BEEF; b = 32'd0; md_use_d = 1'b1;
        tick; tick; tick;
        reset = 1'b0; start = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stall); end
        n_cmp++; if (hi !== 32'd0) begin n_err++; $display("FAIL reset_hi: got %h want 0", hi); end
        n_cmp++; if (lo !== 32'd0) begin n_err++; $display("FAIL reset_lo: got %h want 0", lo); end
        m_hi = 32'd0; m_lo = 32'd0;
        md_use_d = 1'b0;
        tick;
    endtask

    task automatic test_vectors;
        int lat, elat;
        logic st, chg;
        run_op(3'd0, 32'hFFFF_FFFF, 32'd2, lat, st, chg); model_op(3'd0, 32'hFFFF_FFFF, 32'd2, elat);
        n_cmp++; if (lat != 5) begin n_err++; $display("FAIL mult_lat: got %0d want 5", lat); end
        n_cmp++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFE) begin
            n_err++; $display("FAIL mult_res: got %h_%h want ffffffff_fffffffe", hi, lo); end
        n_cmp++; if (chg !== 1'b0) begin n_err++; $display("FAIL mult_early: got %b want 0", chg); end
        run_op(3'd1, 32'hFFFF_FFFF, 32'd2, lat, st, chg); model_op(3'd1, 32'hFFFF_FFFF, 32'd2, elat);
        n_cmp++; if (hi !== 32'h0000_0001 || lo !== 32'hFFFF_FFFE) begin
            n_err++; $display("FAIL multu_res: got %h_%h want 00000001_fffffffe", hi, lo); end
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, lat, st, chg); model_op(3'd2, 32'hFFFF_FFF9, 32'd2, elat);
        n_cmp++; if (lat != 10) begin n_err++; $display("FAIL div_lat: got %0d want 10", lat); end
        n_cmp++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
            n_err++; $display("FAIL div_res: got %h_%h want ffffffff_fffffffd", hi, lo); end
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, lat, st, chg);
        model_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, elat);
        n_cmp++; if (hi !== 32'd0 || lo !== 32'h8000_0000) begin
            n_err++; $display("FAIL div_ovf: got %h_%h want 00000000_80000000", hi, lo); end
        run_op(3'd4, 32'h1234, 32'd0, lat, st, chg); model_op(3'd4, 32'h1234, 32'd0, elat);
        n_cmp++; if (lat != 0) begin n_err++; $display("FAIL mthi_lat: got %0d want 0", lat); end
        run_op(3'd5, 32'h5678, 32'd0, lat, st, chg); model_op(3'd5, 32'h5678, 32'd0, elat);
        run_op(3'd3, 32'h9999, 32'd0, lat, st, chg); model_op(3'd3, 32'h9999, 32'd0, elat);
        n_cmp++; if (lat != 10) begin n_err++; $display("FAIL divz_lat: got %0d want 10", lat); end
        n_cmp++; if (hi !== 32'h1234 || lo !== 32'h5678) begin
            n_err++; $display("FAIL divz_res: got %h_%h want 00001234_00005678", hi, lo); end
    endtask

    task automatic test_stall;
        int st_cnt, bz, elat;
        md_use_d = 1'b1;
        op = 3'd0; a = 32'd3; b = 32'hFFFF_FFFC; start = 1'b1;
        #1;
        st_cnt = stall ? 1 : 0;
        bz = 0;
        tick;
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 1) begin
                op = 3'd3; a = 32'd100; b = 32'd7; start = 1'b1;
            end
            #1;
            if (stall === 1'b1) st_cnt++;
            if (busy === 1'b1) bz++;
            tick;
            start = 1'b0;
        end
        model_op(3'd0, 32'd3, 32'hFFFF_FFFC, elat);
        n_cmp++; if (st_cnt != 6) begin n_err++; $display("FAIL stall_cycles: got %0d want 6", st_cnt); end
        n_cmp++; if (bz != elat) begin n_err++; $display("FAIL stall_busy: got %0d want %0d", bz, elat); end
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL stall_end: got %b want 0", stall); end
        n_cmp++; if (hi !== m_hi || lo !== m_lo) begin
            n_err++; $display("FAIL ignored_start: got %h_%h want %h_%h", hi, lo, m_hi, m_lo); end
        md_use_d = 1'b0;
    endtask

    task automatic test_abort;
        int lat, bad;
        logic st, chg;
        run_op(3'd4, 32'hAAAA, 32'd0, lat, st, chg);
        run_op(3'd5, 32'h5555, 32'd0, lat, st, chg);
        op = 3'd2; a = 32'd1000; b = 32'd3; start = 1'b1;
        tick;
        start = 1'b0;
        tick; tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_cmp++; if (hi !== 32'd0 || lo !== 32'd0) begin
            n_err++; $display("FAIL abort_hilo: got %h_%h want 0_0", hi, lo); end
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            tick;
            if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) bad++;
        end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL abort_late: got %0d bad cycles want 0", bad); end
        m_hi = 32'd0; m_lo = 32'd0;
    endtask

    task automatic test_back_to_back;
        int elat, bz, n;
        logic [31:0] x1, y1, x2, y2;
        x1 = $urandom; y1 = $urandom; x2 = $urandom; y2 = $urandom_range(1, 5000);
        op = 3'd0; a = x1; b = y1; start = 1'b1;
        tick;
        start = 1'b0;
        bz = (busy === 1'b1) ? 1 : 0;
        for (int i = 0; i < 4; i++) begin
            tick;
            if (busy === 1'b1) bz++;
        end
        op = 3'd2; a = x2; b = y2; start = 1'b1;
        tick;
        start = 1'b0;
        model_op(3'd0, x1, y1, elat);
        n_cmp++; if (bz != 5) begin n_err++; $display("FAIL b2b_first_busy: got %0d want 5", bz); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept: got %b want 1", busy); end
        n_cmp++; if (hi !== m_hi || lo !== m_lo) begin
            n_err++; $display("FAIL b2b_first_res: got %h_%h want %h_%h", hi, lo, m_hi, m_lo); end
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            tick;
        end
        model_op(3'd2, x2, y2, elat);
        n_cmp++; if (n != elat) begin n_err++; $display("FAIL b2b_second_lat: got %0d want %0d", n, elat); end
        n_cmp++; if (hi !== m_hi || lo !== m_lo) begin
            n_err++; $display("FAIL b2b_second_res: got %h_%h want %h_%h", hi, lo, m_hi, m_lo); end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random;
        int lat, elat;
        logic st, chg;
        logic [2:0] o;
        logic [31:0] x, y;
        for (int i = 0; i < 60; i++) begin
            o = 3'($urandom_range(0, 7));
            x = pick();
            y = pick();
            md_use_d = 1'($urandom_range(0, 1));
            model_op(o, x, y, elat);
            run_op(o, x, y, lat, st, chg);
            n_cmp++; if (lat != elat) begin
                n_err++; $display("FAIL rnd_lat[%0d] op%0d: got %0d want %0d", i, o, lat, elat); end
            n_cmp++; if (st !== (md_use_d && elat != 0)) begin
                n_err++; $display("FAIL rnd_stall[%0d] op%0d: got %b want %b", i, o, st,
                                  (md_use_d && elat != 0)); end
            n_cmp++; if (chg !== 1'b0) begin
                n_err++; $display("FAIL rnd_early[%0d] op%0d: got %b want 0", i, o, chg); end
            n_cmp++; if (hi !== m_hi || lo !== m_lo) begin
                n_err++; $display("FAIL rnd_res[%0d] op%0d a=%h b=%h: got %h_%h want %h_%h",
                                  i, o, x, y, hi, lo, m_hi, m_lo); end
        end
        md_use_d = 1'b0;
    endtask

`ifdef MDU_MADD_EN
    task automatic test_madd;
        int lat, elat;
        logic st, chg;
        run_op(3'd4, 32'd0, 32'd0, lat, st, chg); model_op(3'd4, 32'd0, 32'd0, elat);
        run_op(3'd5, 32'hFFFF_FFFF, 32'd0, lat, st, chg); model_op(3'd5, 32'hFFFF_FFFF, 32'd0, elat);
        run_op(3'd7, 32'd1, 32'd1, lat, st, chg); model_op(3'd7, 32'd1, 32'd1, elat);
        n_cmp++; if (lat != 5) begin n_err++; $display("FAIL maddu_lat: got %0d want 5", lat); end
        n_cmp++; if (hi !== 32'd1 || lo !== 32'd0) begin
            n_err++; $display("FAIL maddu_res: got %h_%h want 00000001_00000000", hi, lo); end
        run_op(3'd4, 32'd0, 32'd0, lat, st, chg); model_op(3'd4, 32'd0, 32'd0, elat);
        run_op(3'd5, 32'd5, 32'd0, lat, st, chg); model_op(3'd5, 32'd5, 32'd0, elat);
        run_op(3'd6, 32'hFFFF_FFFF, 32'd3, lat, st, chg); model_op(3'd6, 32'hFFFF_FFFF, 32'd3, elat);
        n_cmp++; if (hi !== 32'd0 || lo !== 32'd2) begin
            n_err++; $display("FAIL madd_res: got %h_%h want 00000000_00000002", hi, lo); end
    endtask
`endif

    initial begin
        reset = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0; md_use_d = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        test_reset();
        test_vectors();
        test_stall();
        test_abort();
        test_back_to_back();
`ifdef MDU_MADD_EN
        test_madd();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
